idli_sqi_mem_m: RTL

Behavioural-plus-synthesisable model of a quad-SPI (SQI) SRAM that sits directly on the core's SQI port in the test bench, one instance per chip select (low and high halves). It consumes the core's SCK, CS and SIO-out nibbles and produces the SIO-in nibbles. It implements sequential-mode READ (0x03) and WRITE (0x02) with byte auto-increment, so programs and data can be served to the core without an external memory script.

---
 rtl/idli_sqi_mem_m.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/idli_sqi_mem_m.sv
// idli_sqi_mem_m -- quad-SPI (SQI) SRAM model for the core's SQI port.
// Serves sequential-mode READ (0x03) and WRITE (0x02) with byte
// auto-increment. One instance per chip select.
//
// Ports:
//   i_mem_gck     clock shared with the core
//   i_mem_rst_n   synchronous active-low reset
//   i_mem_sck     SQI clock from the core, used as a beat enable
//   i_mem_cs      chip select, active-low
//   i_mem_sio     nibble driven by the core
//   o_mem_sio     nibble returned to the core (registered)
//   o_mem_sio_en  high while o_mem_sio carries read data
//   o_mem_err     sticky: current transaction had an unsupported instruction
module idli_sqi_mem_m #(
  parameter int ADDR_W = 17
) (
  input  logic       i_mem_gck,
  input  logic       i_mem_rst_n,
  input  logic       i_mem_sck,
  input  logic       i_mem_cs,
  input  logic [3:0] i_mem_sio,
  output logic [3:0] o_mem_sio,
  output logic       o_mem_sio_en,
  output logic       o_mem_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INSTR,
    ST_ADDR,
    ST_DUMMY,
    ST_READ,
    ST_WRITE,
    ST_ERR
  } state_t;

  state_t            state_q;
  logic [2:0]        cnt_q;     // beat counter within ADDR / DUMMY
  logic              phase_q;   // 0: high nibble next, 1: low nibble next
  logic [3:0]        hi_q;      // instruction / write-data high nibble
  logic              is_read_q;
  logic              armed_q;   // a CS-high has been seen since reset
  logic [ADDR_W-1:0] addr_q;

  logic [7:0] mem_q [0:(2**ADDR_W)-1];

  logic              beat;
  logic              wr_en;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] addr_shift;

  // NOTE: every always_comb output gets a value before any branch, so no latch is inferred.
  always_comb begin
    beat       = !i_mem_cs && i_mem_sck;
    addr_inc   = addr_q + 1'b1;   // natural wrap modulo 2^ADDR_W
    // Upper address bits shift out of the register and are dropped.
    addr_shift = {addr_q[ADDR_W-5:0], i_mem_sio};
    wr_en      = i_mem_rst_n && beat && (state_q == ST_WRITE) && phase_q;
  end

  // NOTE: the storage array has no reset; contents survive reset and start undefined.
  always_ff @(posedge i_mem_gck) begin
    if (wr_en) mem_q[addr_q] <= {hi_q, i_mem_sio};
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_mem_gck) begin
    if (!i_mem_rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      is_read_q    <= 1'b0;
      armed_q      <= 1'b0;
      addr_q       <= '0;
      o_mem_sio    <= '0;
      o_mem_sio_en <= 1'b0;
      o_mem_err    <= 1'b0;
    end else if (i_mem_cs) begin
      // Deselect wins over SCK; a half-written byte is simply dropped.
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      phase_q      <= 1'b0;
      o_mem_sio_en <= 1'b0;
      armed_q      <= 1'b1;
    end else if (i_mem_sck) begin
      unique case (state_q)
        ST_IDLE: begin
          // After a reset, wait for a fresh CS assertion before decoding.
          if (armed_q) begin
            hi_q      <= i_mem_sio;
            o_mem_err <= 1'b0;
            state_q   <= ST_INSTR;
          end
        end
        ST_INSTR: begin
          cnt_q <= '0;
          if ({hi_q, i_mem_sio} == 8'h03) begin
            is_read_q <= 1'b1;
            state_q   <= ST_ADDR;
          end else if ({hi_q, i_mem_sio} == 8'h02) begin
            is_read_q <= 1'b0;
            state_q   <= ST_ADDR;
          end else begin
            o_mem_err <= 1'b1;
            state_q   <= ST_ERR;
          end
        end
        ST_ADDR: begin
          addr_q <= addr_shift;
          if (cnt_q == 3'd5) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            state_q <= is_read_q ? ST_DUMMY : ST_WRITE;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        ST_DUMMY: begin
          if (cnt_q == 3'd1) begin
            // Present the first high nibble so it is stable before the next beat.
            o_mem_sio    <= mem_q[addr_q][7:4];
            o_mem_sio_en <= 1'b1;
            phase_q      <= 1'b1;
            cnt_q        <= '0;
            state_q      <= ST_READ;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        ST_READ: begin
          // phase_q==1: the high nibble is on the bus, load the low one next.
          if (phase_q) begin
            o_mem_sio <= mem_q[addr_q][3:0];
            phase_q   <= 1'b0;
          end else begin
            o_mem_sio <= mem_q[addr_inc][7:4];
            addr_q    <= addr_inc;
            phase_q   <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (!phase_q) begin
            hi_q    <= i_mem_sio;
            phase_q <= 1'b1;
          end else begin
            addr_q  <= addr_inc;
            phase_q <= 1'b0;
          end
        end
        ST_ERR: begin
          state_q <= ST_ERR;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
